// File: rtl/gun_adc_ctl.sv
// XADC DRP sequencer for the light-gun photodiode on VAUX4, with hysteresis light detect.
// Latency: EOC -> drp_den next cycle; drp_drdy -> sample/light one cycle later.
// No backpressure; one request may queue while busy (optional averaging: GUN_ADC_AVG_EN).
module gun_adc_ctl #(
  parameter logic [6:0]  DRP_ADDR  = 7'h14,
  parameter logic [4:0]  CHANNEL   = 5'h14,
  parameter logic [11:0] THRESH_HI = 12'hA00,
  parameter logic [11:0] THRESH_LO = 12'h800,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        light,
  output logic        light_rise,
  output logic        drp_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic          pending;
  logic [TW-1:0] tmo_cnt;
  logic          trig, capture, tmo_hit;
  logic [11:0]   raw, new_sample;
  logic          unused_do_lsb;

  assign trig          = eoc_in && (channel_in == CHANNEL);
  assign raw           = drp_do[15:4];
  assign unused_do_lsb = ^drp_do[3:0];
  assign capture       = (state == WAIT) && drp_drdy;
  assign tmo_hit       = (state == WAIT) && !drp_drdy && (tmo_cnt == TMO_LAST);

  assign drp_daddr = DRP_ADDR;
  assign drp_dwe   = 1'b0;
  assign drp_di    = 16'h0000;

`ifdef GUN_ADC_AVG_EN
  // Sum includes the incoming raw value so averaging adds no latency.
  logic [2:0][11:0] avg_buf;
  logic [13:0]      avg_sum;
  logic             unused_avg_lsb;

  assign avg_sum        = 14'(raw) + 14'(avg_buf[0]) + 14'(avg_buf[1]) + 14'(avg_buf[2]);
  assign new_sample     = avg_sum[13:2];
  assign unused_avg_lsb = ^avg_sum[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_buf <= '0;
    end else if (capture) begin
      avg_buf <= {avg_buf[1], avg_buf[0], raw};
    end
  end
`else
  assign new_sample = raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig || pending) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT: begin
        if (drp_drdy) state_nxt = DONE;
        else if (tmo_cnt == TMO_LAST) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= 1'b0;
      tmo_cnt      <= '0;
      drp_den      <= 1'b0;
      sample       <= 12'h000;
      sample_valid <= 1'b0;
      light        <= 1'b0;
      light_rise   <= 1'b0;
      drp_err      <= 1'b0;
    end else begin
      drp_den      <= (state_nxt == REQ);
      sample_valid <= 1'b0;
      light_rise   <= 1'b0;
      drp_err      <= tmo_hit;
      tmo_cnt      <= (state == WAIT) ? tmo_cnt + 1'b1 : '0;

      // One-deep request queue; extra EOCs while busy are dropped.
      if ((state == IDLE) && (state_nxt == REQ)) pending <= 1'b0;
      else if (trig && (state != IDLE))          pending <= 1'b1;

      if (capture) begin
        sample       <= new_sample;
        sample_valid <= 1'b1;
        if (!light && (new_sample >= THRESH_HI)) begin
          light      <= 1'b1;
          light_rise <= 1'b1;
        end else if (light && (new_sample < THRESH_LO)) begin
          light      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gun_adc_ctl.sv
// Bench for gun_adc_ctl: vector table plus hand sequences, scoreboard checked on sample_valid.
module tb_gun_adc_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eoc_in = 1'b0;
  logic [4:0]  channel_in = 5'h00;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'h0000;
  logic        drp_drdy = 1'b0;
  logic [11:0] sample;
  logic        sample_valid, light, light_rise, drp_err;

  gun_adc_ctl dut (
    .clk(clk), .rst_n(rst_n), .eoc_in(eoc_in), .channel_in(channel_in),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .sample(sample), .sample_valid(sample_valid),
    .light(light), .light_rise(light_rise), .drp_err(drp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] s;
    bit          l;
    bit          r;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [11:0] raw;
    logic [11:0] s;
    bit          l;
    bit          r;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int den_cnt = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  bit prev_den = 1'b0;
  bit prev_valid = 1'b0;

  // Reference model state: light level, last sample, raw history for averaging.
  bit          m_light;
  logic [11:0] m_last;
  logic [11:0] m_h0, m_h1, m_h2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_light = 1'b0;
    m_last  = 12'h000;
    m_h0 = 12'h000; m_h1 = 12'h000; m_h2 = 12'h000;
  endtask

  function automatic exp_t model_exp(input logic [11:0] raw);
    exp_t        e;
    logic [13:0] sum;
`ifdef GUN_ADC_AVG_EN
    sum  = 14'(raw) + 14'(m_h0) + 14'(m_h1) + 14'(m_h2);
    e.s  = sum[13:2];
    m_h2 = m_h1; m_h1 = m_h0; m_h0 = raw;
`else
    sum  = 14'(raw);
    e.s  = sum[11:0];
`endif
    e.r = 1'b0;
    if (!m_light && e.s >= 12'hA00) begin
      m_light = 1'b1;
      e.r = 1'b1;
    end else if (m_light && e.s < 12'h800) begin
      m_light = 1'b0;
    end
    e.l   = m_light;
    e.cyc = 0;
    m_last = e.s;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_eoc(input logic [4:0] ch);
    eoc_in = 1'b1;
    channel_in = ch;
    tick(1);
    eoc_in = 1'b0;
    channel_in = 5'h00;
  endtask

  task automatic wait_den(output int c);
    c = -1;
    for (int i = 0; i < 16; i++) begin
      if (drp_den) begin
        c = cyc;
        break;
      end
      tick(1);
    end
    if (c < 0) check("den_seen", 0, 1);
  endtask

  task automatic give_drdy(input logic [11:0] raw, input exp_t e);
    exp_t q;
    q = e;
    drp_do = {raw, 4'($urandom_range(0, 15))};
    drp_drdy = 1'b1;
    q.cyc = cyc + 1;
    sb.push_back(q);
    tick(1);
    drp_drdy = 1'b0;
    drp_do = 16'(  $urandom);
  endtask

  task automatic model_read(input logic [11:0] raw, input int dly);
    int   c;
    exp_t e;
    issue_eoc(5'h14);
    wait_den(c);
    tick(dly);
    e = model_exp(raw);
    give_drdy(raw, e);
    tick(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_den"},    drp_den, 0);
    check({tag, "_daddr"},  drp_daddr, 7'h14);
    check({tag, "_sample"}, sample, 12'h000);
    check({tag, "_valid"},  sample_valid, 0);
    check({tag, "_light"},  light, 0);
    check({tag, "_rise"},   light_rise, 0);
    check({tag, "_err"},    drp_err, 0);
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (drp_den) begin
        den_cnt++;
        check("den_daddr", drp_daddr, 7'h14);
        check("den_single", prev_den, 0);
        check("dwe_di_zero", {drp_dwe, drp_di}, 0);
      end
      if (drp_err) err_cnt++;
      if (light_rise) check("rise_with_valid", sample_valid, 1);
      if (sample_valid) begin
        valid_cnt++;
        check("valid_single", prev_valid, 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: sample=0x%0h, required no sample_valid", sample);
        end else begin
          mon_e = sb.pop_front();
          check("sample", sample, mon_e.s);
          check("light", light, mon_e.l);
          check("light_rise", light_rise, mon_e.r);
          check("valid_cycle", cyc, mon_e.cyc);
        end
      end
    end
    prev_den   = drp_den && rst_n;
    prev_valid = sample_valid && rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required natural end");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c, ec, den0, err0, val0;
    exp_t e;

`ifdef GUN_ADC_AVG_EN
    tbl.push_back('{12'hC00, 12'h300, 1'b0, 1'b0});
    tbl.push_back('{12'hC00, 12'h600, 1'b0, 1'b0});
    tbl.push_back('{12'hC00, 12'h900, 1'b0, 1'b0});
    tbl.push_back('{12'hC00, 12'hC00, 1'b1, 1'b1});
    tbl.push_back('{12'h000, 12'h900, 1'b1, 1'b0});
    tbl.push_back('{12'h000, 12'h600, 1'b0, 1'b0});
`else
    tbl.push_back('{12'h900, 12'h900, 1'b0, 1'b0});
    tbl.push_back('{12'hA00, 12'hA00, 1'b1, 1'b1});
    tbl.push_back('{12'h900, 12'h900, 1'b1, 1'b0});
    tbl.push_back('{12'h800, 12'h800, 1'b1, 1'b0});
    tbl.push_back('{12'h7FF, 12'h7FF, 1'b0, 1'b0});
    tbl.push_back('{12'h9FF, 12'h9FF, 1'b0, 1'b0});
    tbl.push_back('{12'hB00, 12'hB00, 1'b1, 1'b1});
    tbl.push_back('{12'hFFF, 12'hFFF, 1'b1, 1'b0});
    tbl.push_back('{12'h000, 12'h000, 1'b0, 1'b0});
`endif

    model_reset();
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Vector table: one full DRP read per entry, varying drdy delay.
    for (int i = 0; i < tbl.size(); i++) begin
      issue_eoc(5'h14);
      wait_den(c);
      tick(1 + (i % 4));
      e = model_exp(tbl[i].raw);
      e.s = tbl[i].s;
      e.l = tbl[i].l;
      e.r = tbl[i].r;
      give_drdy(tbl[i].raw, e);
      tick(3);
    end
    check("table_reads", den_cnt, tbl.size());

    // Non-matching channel must not start a read.
    den0 = den_cnt;
    issue_eoc(5'h03);
    tick(6);
    check("filter_no_read", den_cnt, den0);

    // Two qualifying EOCs during WAIT: exactly one extra read afterwards.
    issue_eoc(5'h14);
    wait_den(c);
    tick(1);
    issue_eoc(5'h14);
    tick(1);
    issue_eoc(5'h14);
    e = model_exp(12'hA50);
    give_drdy(12'hA50, e);
    wait_den(c);
    tick(2);
    e = model_exp(12'h100);
    give_drdy(12'h100, e);
    tick(20);
    check("pending_reads", den_cnt, den0 + 2);

    // Timeout with no drdy.
    err0 = err_cnt;
    val0 = valid_cnt;
    issue_eoc(5'h14);
    wait_den(c);
    ec = -1;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (drp_err) begin
        ec = cyc;
        break;
      end
    end
    check("timeout_err_cycle", ec - c, 65);
    tick(1);
    check("timeout_err_width", drp_err, 0);
    check("timeout_sample_kept", sample, m_last);
    check("timeout_no_valid", valid_cnt, val0);
    check("timeout_err_count", err_cnt, err0 + 1);
    model_read(12'hC40, 2);

    // Reset in the middle of WAIT, then a stray drdy.
    issue_eoc(5'h14);
    wait_den(c);
    tick(1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("midreset");
    tick(1);
    rst_n = 1'b1;
    den0 = den_cnt;
    val0 = valid_cnt;
    tick(1);
    drp_do = 16'hFFF0;
    drp_drdy = 1'b1;
    tick(1);
    drp_drdy = 1'b0;
    tick(5);
    check("stray_no_valid", valid_cnt, val0);
    check("stray_no_read", den_cnt, den0);
    check_reset_outputs("after_stray");

    // Recovery after reset.
    model_read(12'hB00, 3);
    tick(4);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
